// File: rtl/rdma_rc_sq_segmenter.sv
// RC send-queue segmenter: splits one SEND work request into MTU-sized packet
// headers (FIRST/MIDDLE/LAST/ONLY) while the QP is in RTS, aborting cleanly if it leaves.
module rdma_rc_sq_segmenter #(
    parameter int QPN_WIDTH = 16,
    parameter int LEN_WIDTH = 32,
    parameter int PSN_WIDTH = 24,
    parameter int MTU_LOG2  = 10
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           qp_state,
    input  logic                 qp_ready,
    input  logic [QPN_WIDTH-1:0] remote_qpn,
    input  logic [PSN_WIDTH-1:0] init_psn,
    input  logic                 wqe_valid,
    output logic                 wqe_ready,
    input  logic [LEN_WIDTH-1:0] wqe_len,
    output logic                 pkt_valid,
    input  logic                 pkt_ready,
    output logic [QPN_WIDTH-1:0] pkt_dqpn,
    output logic [PSN_WIDTH-1:0] pkt_psn,
    output logic [1:0]           pkt_opcode,
    output logic [MTU_LOG2:0]    pkt_len,
    output logic                 sq_busy,
    output logic                 abort_pulse
);

    localparam logic [2:0] QP_RTS = 3'b011;

    localparam logic [1:0] OP_ONLY   = 2'b00;
    localparam logic [1:0] OP_FIRST  = 2'b01;
    localparam logic [1:0] OP_MIDDLE = 2'b10;
    localparam logic [1:0] OP_LAST   = 2'b11;

    localparam logic [LEN_WIDTH-1:0] MTU_BYTES = LEN_WIDTH'(1) << MTU_LOG2;
    localparam logic [MTU_LOG2:0]    MTU_PKT   = {1'b1, {MTU_LOG2{1'b0}}};

    typedef enum logic {
        IDLE,
        SEG
    } seg_state_t;

    seg_state_t state, state_nxt;

    logic                 in_rts;
    logic                 rts_q;
    logic                 rts_entry;
    logic [PSN_WIDTH-1:0] next_psn;
    logic [QPN_WIDTH-1:0] dqpn;
    logic [LEN_WIDTH-1:0] remaining;
    logic                 first;
    logic                 is_tail;
    logic [MTU_LOG2:0]    seg_len;
    logic [1:0]           seg_opcode;
    logic                 in_seg;
    logic                 can_accept;
    logic                 accept;
    logic                 pkt_fire;
    logic                 abort;

    assign in_rts    = (qp_state == QP_RTS) && qp_ready;
    assign rts_entry = in_rts && !rts_q;
    assign is_tail   = remaining <= MTU_BYTES;
    assign seg_len   = is_tail ? remaining[MTU_LOG2:0] : MTU_PKT;
    assign in_seg    = (state == SEG);

    always_comb begin
        if (first) begin
            seg_opcode = is_tail ? OP_ONLY : OP_FIRST;
        end else begin
            seg_opcode = is_tail ? OP_LAST : OP_MIDDLE;
        end
    end

    // Header fields read as zero whenever no packet is being offered
    assign pkt_dqpn   = in_seg ? dqpn       : '0;
    assign pkt_psn    = in_seg ? next_psn   : '0;
    assign pkt_opcode = in_seg ? seg_opcode : 2'b00;
    assign pkt_len    = in_seg ? seg_len    : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        can_accept = 1'b0;
        accept     = 1'b0;
        pkt_valid  = 1'b0;
        sq_busy    = 1'b0;
        pkt_fire   = 1'b0;
        abort      = 1'b0;
        case (state)
            IDLE: begin
                can_accept = in_rts && rts_q;
                if (wqe_valid && can_accept) begin
                    accept    = 1'b1;
                    state_nxt = SEG;
                end
            end
            SEG: begin
                pkt_valid = 1'b1;
                sq_busy   = 1'b1;
                pkt_fire  = pkt_ready;
                // A tail packet handshaking as RTS drops is a normal exit, not an abort
                if (pkt_fire && is_tail) begin
                    state_nxt = IDLE;
                end else if (!in_rts) begin
                    state_nxt = IDLE;
                    abort     = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        wqe_ready = can_accept;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rts_q       <= 1'b0;
            abort_pulse <= 1'b0;
            remaining   <= '0;
            first       <= 1'b0;
            next_psn    <= '0;
            dqpn        <= '0;
        end else begin
            rts_q       <= in_rts;
            abort_pulse <= abort;

            if (abort) begin
                remaining <= '0;
                first     <= 1'b0;
            end else if (accept) begin
                remaining <= wqe_len;
                first     <= 1'b1;
            end else if (pkt_fire) begin
                remaining <= remaining - LEN_WIDTH'(seg_len);
                first     <= 1'b0;
            end

            // PSN is never rewound on abort; only a fresh RTS entry reloads it
            if (rts_entry) begin
                next_psn <= init_psn;
                dqpn     <= remote_qpn;
            end else if (pkt_fire) begin
                next_psn <= next_psn + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rdma_rc_sq_segmenter.sv
// Directed self-checking bench for rdma_rc_sq_segmenter with hand-computed
// packet headers and immediate assertions at each comparison point.
module tb_rdma_rc_sq_segmenter;

    localparam logic [2:0] ST_RESET = 3'b000;
    localparam logic [2:0] ST_RTR   = 3'b010;
    localparam logic [2:0] ST_RTS   = 3'b011;
    localparam logic [2:0] ST_ERROR = 3'b111;

    localparam logic [1:0] OP_ONLY   = 2'b00;
    localparam logic [1:0] OP_FIRST  = 2'b01;
    localparam logic [1:0] OP_MIDDLE = 2'b10;
    localparam logic [1:0] OP_LAST   = 2'b11;

    localparam logic [15:0] DQPN = 16'hABCD;

    logic        clk;
    logic        rst;
    logic [2:0]  qp_state;
    logic        qp_ready;
    logic [15:0] remote_qpn;
    logic [23:0] init_psn;
    logic        wqe_valid;
    logic        wqe_ready;
    logic [31:0] wqe_len;
    logic        pkt_valid;
    logic        pkt_ready;
    logic [15:0] pkt_dqpn;
    logic [23:0] pkt_psn;
    logic [1:0]  pkt_opcode;
    logic [10:0] pkt_len;
    logic        sq_busy;
    logic        abort_pulse;

    int n_checks = 0;
    int n_fail   = 0;

    rdma_rc_sq_segmenter dut (
        .clk         (clk),
        .rst         (rst),
        .qp_state    (qp_state),
        .qp_ready    (qp_ready),
        .remote_qpn  (remote_qpn),
        .init_psn    (init_psn),
        .wqe_valid   (wqe_valid),
        .wqe_ready   (wqe_ready),
        .wqe_len     (wqe_len),
        .pkt_valid   (pkt_valid),
        .pkt_ready   (pkt_ready),
        .pkt_dqpn    (pkt_dqpn),
        .pkt_psn     (pkt_psn),
        .pkt_opcode  (pkt_opcode),
        .pkt_len     (pkt_len),
        .sq_busy     (sq_busy),
        .abort_pulse (abort_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] st, input logic rdy, input logic wv,
                                 input logic [31:0] len, input logic pr);
        qp_state  = st;
        qp_ready  = rdy;
        wqe_valid = wv;
        wqe_len   = len;
        pkt_ready = pr;
    endtask

    task automatic nextCycle();
        @(negedge clk);
        #1;
    endtask

    task automatic checkPkt(input string tag, input logic [1:0] op, input logic [10:0] len, input logic [23:0] psn);
        checkOutput($sformatf("%s.valid", tag), pkt_valid, 1);
        checkOutput($sformatf("%s.busy", tag), sq_busy, 1);
        checkOutput($sformatf("%s.opcode", tag), pkt_opcode, op);
        checkOutput($sformatf("%s.len", tag), pkt_len, len);
        checkOutput($sformatf("%s.psn", tag), pkt_psn, psn);
        checkOutput($sformatf("%s.dqpn", tag), pkt_dqpn, DQPN);
    endtask

    task automatic checkIdle(input string tag);
        checkOutput($sformatf("%s.valid", tag), pkt_valid, 0);
        checkOutput($sformatf("%s.busy", tag), sq_busy, 0);
    endtask

    // Leaves RTS for one cycle, then re-enters so the new init_psn is loaded
    task automatic enterRts(input logic [23:0] psn);
        qp_state = ST_RTR;
        @(negedge clk);
        init_psn = psn;
        qp_state = ST_RTS;
        @(negedge clk);
    endtask

    task automatic sendWqe(input logic [31:0] len);
        wqe_valid = 1'b1;
        wqe_len   = len;
        #1;
        checkOutput("wqe_ready.accept", wqe_ready, 1);
        @(negedge clk);
        wqe_valid = 1'b0;
        #1;
    endtask

    initial begin
        rst        = 1'b1;
        remote_qpn = DQPN;
        init_psn   = 24'h000100;
        applyStimulus(ST_RESET, 1'b0, 1'b0, 32'd0, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        checkIdle("reset");
        checkOutput("reset.wqe_ready", wqe_ready, 0);
        checkOutput("reset.abort", abort_pulse, 0);
        checkOutput("reset.psn", pkt_psn, 0);
        checkOutput("reset.dqpn", pkt_dqpn, 0);
        checkOutput("reset.len", pkt_len, 0);
        checkOutput("reset.opcode", pkt_opcode, 0);
        rst = 1'b0;
        @(negedge clk);

        // 3000-byte message from a fresh RTS entry
        applyStimulus(ST_RTS, 1'b1, 1'b1, 32'd3000, 1'b1);
        #1;
        checkOutput("t1.entry_wqe_ready", wqe_ready, 0);
        nextCycle();
        checkOutput("t1.wqe_ready", wqe_ready, 1);
        @(negedge clk);
        wqe_valid = 1'b0;
        #1;
        checkOutput("t1.wqe_ready_seg", wqe_ready, 0);
        checkPkt("t1.first", OP_FIRST, 11'd1024, 24'h000100);
        nextCycle();
        checkPkt("t1.middle", OP_MIDDLE, 11'd1024, 24'h000101);
        nextCycle();
        checkPkt("t1.last", OP_LAST, 11'd952, 24'h000102);
        nextCycle();
        checkIdle("t1.done");
        checkOutput("t1.done_wqe_ready", wqe_ready, 1);

        // Zero-length message and the PSN it leaves behind
        enterRts(24'h000200);
        sendWqe(32'd0);
        checkPkt("t2.only", OP_ONLY, 11'd0, 24'h000200);
        nextCycle();
        checkIdle("t2.done");
        @(negedge clk);
        sendWqe(32'd1500);
        checkPkt("t2.first", OP_FIRST, 11'd1024, 24'h000201);
        nextCycle();
        checkPkt("t2.last", OP_LAST, 11'd476, 24'h000202);
        nextCycle();
        checkIdle("t2.done2");

        // PSN wrap across 2^24
        enterRts(24'hFFFFFE);
        sendWqe(32'd4096);
        checkPkt("t3.p0", OP_FIRST, 11'd1024, 24'hFFFFFE);
        nextCycle();
        checkPkt("t3.p1", OP_MIDDLE, 11'd1024, 24'hFFFFFF);
        nextCycle();
        checkPkt("t3.p2", OP_MIDDLE, 11'd1024, 24'h000000);
        nextCycle();
        checkPkt("t3.p3", OP_LAST, 11'd1024, 24'h000001);
        nextCycle();
        checkIdle("t3.done");

        // Backpressure on the FIRST header for five cycles
        @(negedge clk);
        pkt_ready = 1'b0;
        sendWqe(32'd2048);
        for (int i = 0; i < 5; i++) begin
            checkPkt($sformatf("t4.hold%0d", i), OP_FIRST, 11'd1024, 24'h000002);
            nextCycle();
        end
        pkt_ready = 1'b1;
        #1;
        checkPkt("t4.release", OP_FIRST, 11'd1024, 24'h000002);
        nextCycle();
        checkPkt("t4.last", OP_LAST, 11'd1024, 24'h000003);
        nextCycle();
        checkIdle("t4.done");

        // LAST handshakes in the same cycle the QP drops: normal exit
        enterRts(24'h000700);
        sendWqe(32'd2048);
        checkPkt("t5a.first", OP_FIRST, 11'd1024, 24'h000700);
        nextCycle();
        checkPkt("t5a.last", OP_LAST, 11'd1024, 24'h000701);
        qp_state = ST_ERROR;
        nextCycle();
        checkIdle("t5a.exit");
        checkOutput("t5a.no_abort", abort_pulse, 0);

        // Abort mid-message, then re-entry with a new PSN
        enterRts(24'h000400);
        sendWqe(32'd4096);
        checkPkt("t5.first", OP_FIRST, 11'd1024, 24'h000400);
        nextCycle();
        checkPkt("t5.middle", OP_MIDDLE, 11'd1024, 24'h000401);
        qp_state  = ST_RESET;
        pkt_ready = 1'b0;
        nextCycle();
        checkOutput("t5.abort_pulse", abort_pulse, 1);
        checkIdle("t5.aborted");
        checkOutput("t5.wqe_ready_abort", wqe_ready, 0);
        wqe_valid = 1'b1;
        wqe_len   = 32'd100;
        nextCycle();
        checkOutput("t5.abort_one_cycle", abort_pulse, 0);
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("t5.blocked%0d", i), wqe_ready, 0);
            checkOutput($sformatf("t5.no_pkt%0d", i), pkt_valid, 0);
            nextCycle();
        end
        init_psn = 24'h000050;
        qp_state = ST_RTS;
        #1;
        checkOutput("t5.entry_wqe_ready", wqe_ready, 0);
        nextCycle();
        checkOutput("t5.reentry_wqe_ready", wqe_ready, 1);
        @(negedge clk);
        wqe_valid = 1'b0;
        #1;
        checkPkt("t5.only", OP_ONLY, 11'd100, 24'h000050);
        pkt_ready = 1'b1;
        nextCycle();
        checkIdle("t5.done");

        // WQE offered outside RTS is ignored until the QP reaches RTS
        applyStimulus(ST_RTR, 1'b1, 1'b1, 32'd700, 1'b1);
        for (int i = 0; i < 10; i++) begin
            #1;
            checkOutput($sformatf("t6.rtr_wqe_ready%0d", i), wqe_ready, 0);
            checkOutput($sformatf("t6.rtr_pkt%0d", i), pkt_valid, 0);
            @(negedge clk);
        end
        init_psn = 24'h000060;
        qp_state = ST_RTS;
        #1;
        checkOutput("t6.entry_wqe_ready", wqe_ready, 0);
        nextCycle();
        checkOutput("t6.wqe_ready", wqe_ready, 1);
        @(negedge clk);
        wqe_valid = 1'b0;
        #1;
        checkPkt("t6.only", OP_ONLY, 11'd700, 24'h000060);
        nextCycle();
        checkIdle("t6.done");

        // Asynchronous reset in the middle of a message
        enterRts(24'h000900);
        sendWqe(32'd4096);
        checkPkt("t7.first", OP_FIRST, 11'd1024, 24'h000900);
        rst = 1'b1;
        #1;
        checkIdle("t7.reset");
        checkOutput("t7.reset_psn", pkt_psn, 0);
        checkOutput("t7.reset_abort", abort_pulse, 0);
        nextCycle();
        checkOutput("t7.reset_abort2", abort_pulse, 0);
        rst = 1'b0;
        #1;
        checkOutput("t7.release_wqe_ready", wqe_ready, 0);
        checkIdle("t7.release");
        nextCycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
